placar_controller: RTL and testbench

PLACAR_CONTROLLER -- requirements
Module: placar_controller

---
 rtl/placar_pkg.sv | 19 +
 rtl/placar_alu.sv | 25 ++
 rtl/placar_controller.sv | 110 +++++++++++
 tb/tb_placar_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/placar_pkg.sv
// rtl/placar_pkg.sv - shared types and constants for the scoreboard controller
package placar_pkg;

    localparam int SCORE_W = 7;
    localparam int PTS_W   = 2;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    typedef enum logic {
        TEAM_A = 1'b0,
        TEAM_B = 1'b1
    } team_t;

endpackage

// File: rtl/placar_alu.sv
// rtl/placar_alu.sv - shared saturating add/subtract unit, clamps to 0..SCORE_MAX
module placar_alu
    import placar_pkg::*;
(
    input  logic [SCORE_W-1:0] score,
    input  logic [PTS_W-1:0]   pts,
    input  logic               sub,
    output logic [SCORE_W-1:0] result
);

    logic [SCORE_W-1:0] pts_ext;
    logic [SCORE_W:0]   sum;

    always_comb begin
        pts_ext = {{(SCORE_W-PTS_W){1'b0}}, pts};
        sum     = {1'b0, score} + {1'b0, pts_ext};
        result  = score;
        if (sub) begin
            result = (score < pts_ext) ? '0 : (score - pts_ext);
        end else begin
            result = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/placar_controller.sv
// rtl/placar_controller.sv - two-team scoreboard, one shared ALU, IDLE/EXEC/WB sequencer
// Optional PLACAR_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module placar_controller
    import placar_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic [PTS_W-1:0]     pts_a,
    input  logic [PTS_W-1:0]     pts_b,
    input  logic                 sub_a,
    input  logic                 sub_b,
    output logic                 ack_a,
    output logic                 ack_b,
    output logic                 busy,
    output logic [SCORE_W-1:0]   score_a,
    output logic [SCORE_W-1:0]   score_b
);

    state_t             state;
    team_t              team;
    logic [PTS_W-1:0]   pts_q;
    logic               sub_q;
    logic [SCORE_W-1:0] result_q;
    logic [SCORE_W-1:0] alu_score;
    logic [SCORE_W-1:0] alu_result;
    logic               grant_b;

`ifdef PLACAR_ROUND_ROBIN_EN
    logic ptr;  // 0 favours team A, 1 favours team B
    assign grant_b = req_b & (~req_a | ptr);
`else
    assign grant_b = req_b & ~req_a;
`endif

    assign alu_score = (team == TEAM_B) ? score_b : score_a;

    placar_alu u_alu (
        .score  (alu_score),
        .pts    (pts_q),
        .sub    (sub_q),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            team     <= TEAM_A;
            pts_q    <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            score_a  <= '0;
            score_b  <= '0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            busy     <= 1'b0;
`ifdef PLACAR_ROUND_ROBIN_EN
            ptr      <= 1'b0;
`endif
        end else if (clr) begin
            state    <= ST_IDLE;
            score_a  <= '0;
            score_b  <= '0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        team  <= grant_b ? TEAM_B : TEAM_A;
                        pts_q <= grant_b ? pts_b : pts_a;
                        sub_q <= grant_b ? sub_b : sub_a;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    ack_a    <= (team == TEAM_A);
                    ack_b    <= (team == TEAM_B);
                    state    <= ST_WB;
                end
                ST_WB: begin
                    if (team == TEAM_B) begin
                        score_b <= result_q;
                    end else begin
                        score_a <= result_q;
                    end
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
`ifdef PLACAR_ROUND_ROBIN_EN
                    ptr   <= ~ptr;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_placar_controller.sv
// tb/tb_placar_controller.sv - self-checking bench: vector table, directed corners, random vs model
module tb_placar_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [1:0] pts_a = 2'd0;
    logic [1:0] pts_b = 2'd0;
    logic       sub_a = 1'b0;
    logic       sub_b = 1'b0;
    logic       ack_a;
    logic       ack_b;
    logic       busy;
    logic [6:0] score_a;
    logic [6:0] score_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int model[2];

    typedef struct {
        bit team;
        int pts;
        bit sub;
        int exp_a;
        int exp_b;
    } vec_t;

    vec_t tbl[8];

    placar_controller dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .req_a   (req_a),
        .req_b   (req_b),
        .pts_a   (pts_a),
        .pts_b   (pts_b),
        .sub_a   (sub_a),
        .sub_b   (sub_b),
        .ack_a   (ack_a),
        .ack_b   (ack_b),
        .busy    (busy),
        .score_a (score_a),
        .score_b (score_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_apply(input int s, input int p, input bit sb);
        int r;
        r = sb ? s - p : s + p;
        if (r < 0) r = 0;
        if (r > 99) r = 99;
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model[0] = 0;
        model[1] = 0;
    endtask

    task automatic check_idle_scores(input string tag);
        check({tag, "_score_a"}, int'(score_a), model[0]);
        check({tag, "_score_b"}, int'(score_b), model[1]);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_acks"}, int'({ack_a, ack_b}), 0);
    endtask

    // Called at a negedge while the DUT is idle; returns at the next idle negedge.
    task automatic do_op(input bit tm, input int p, input bit sb, input bit scramble);
        int waits;
        bit got;
        if (tm == 1'b0) begin
            req_a = 1'b1; pts_a = 2'(p); sub_a = sb;
        end else begin
            req_b = 1'b1; pts_b = 2'(p); sub_b = sb;
        end
        got = 1'b0;
        waits = 0;
        while (!got && waits < 8) begin
            @(negedge clk);
            waits++;
            if (scramble && waits == 1) begin
                if (tm == 1'b0) {pts_a, sub_a} = 3'($urandom);
                else            {pts_b, sub_b} = 3'($urandom);
            end
            if ((tm == 1'b0 && ack_a) || (tm == 1'b1 && ack_b)) got = 1'b1;
        end
        check("ack_seen", int'(got), 1);
        check("ack_latency", waits, 2);
        check("ack_other", int'(tm ? ack_a : ack_b), 0);
        check("busy_wb", int'(busy), 1);
        req_a = 1'b0;
        req_b = 1'b0;
        model[tm] = ref_apply(model[tm], p, sb);
        @(negedge clk);
        check_idle_scores("op");
    endtask

    initial begin
        int exp_order[4];
        tbl[0] = '{1'b0, 3, 1'b0, 3, 0};
        tbl[1] = '{1'b1, 2, 1'b0, 3, 2};
        tbl[2] = '{1'b0, 1, 1'b1, 2, 2};
        tbl[3] = '{1'b0, 0, 1'b0, 2, 2};
        tbl[4] = '{1'b1, 3, 1'b1, 2, 0};
        tbl[5] = '{1'b0, 1, 1'b1, 1, 0};
        tbl[6] = '{1'b0, 3, 1'b1, 0, 0};
        tbl[7] = '{1'b1, 1, 1'b0, 0, 1};

        do_reset();
        check("rst_score_a", int'(score_a), 0);
        check("rst_score_b", int'(score_b), 0);
        check("rst_ack_a", int'(ack_a), 0);
        check("rst_ack_b", int'(ack_b), 0);
        check("rst_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].team, tbl[i].pts, tbl[i].sub, 1'b0);
            check($sformatf("tbl%0d_a", i), int'(score_a), tbl[i].exp_a);
            check($sformatf("tbl%0d_b", i), int'(score_b), tbl[i].exp_b);
        end

        // Climb team B to the ceiling, then exercise the top clamp and a subtract
        for (int i = 0; i < 33; i++) do_op(1'b1, 3, 1'b0, 1'b0);
        check("b_at_max", int'(score_b), 99);
        do_op(1'b1, 1, 1'b1, 1'b0);
        check("b_98", int'(score_b), 98);
        do_op(1'b1, 3, 1'b0, 1'b0);
        check("b_clamp_99", int'(score_b), 99);
        do_op(1'b1, 2, 1'b1, 1'b0);
        check("b_97", int'(score_b), 97);

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // clr during EXEC aborts the operation
        do_op(1'b0, 3, 1'b0, 1'b0);
        req_a = 1'b1; pts_a = 2'd2; sub_a = 1'b0;
        @(negedge clk);
        check("clr_exec_busy", int'(busy), 1);
        clr = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        model[0] = 0;
        model[1] = 0;
        check_idle_scores("clr");
        @(negedge clk);
        check("clr_no_ack_a", int'(ack_a), 0);
        check("clr_idle_busy", int'(busy), 0);

        // clr wins over a simultaneous request
        do_op(1'b1, 1, 1'b0, 1'b0);
        clr = 1'b1;
        req_b = 1'b1; pts_b = 2'd3; sub_b = 1'b0;
        @(negedge clk);
        check("clr_prio_busy", int'(busy), 0);
        check("clr_prio_score_b", int'(score_b), 0);
        clr = 1'b0;
        req_b = 1'b0;
        model[1] = 0;
        @(negedge clk);
        check_idle_scores("clr_prio");

        // reset during WB drops the write and the ack
        do_op(1'b0, 3, 1'b0, 1'b0);
        req_b = 1'b1; pts_b = 2'd2; sub_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wb_ack_b", int'(ack_b), 1);
        reset = 1'b1;
        req_b = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model[0] = 0;
        model[1] = 0;
        check_idle_scores("rst_wb");
        @(negedge clk);
        check("rst_wb_score_b", int'(score_b), 0);

        // Simultaneous requests held high across four operations
`ifdef PLACAR_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        do_reset();
        req_a = 1'b1; pts_a = 2'd1; sub_a = 1'b0;
        req_b = 1'b1; pts_b = 2'd1; sub_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int waits;
            int who;
            waits = 0;
            who = -1;
            while (who < 0 && waits < 8) begin
                @(negedge clk);
                waits++;
                if (ack_a && !ack_b) who = 0;
                else if (ack_b && !ack_a) who = 1;
            end
            check($sformatf("arb%0d_team", k), who, exp_order[k]);
            check($sformatf("arb%0d_gap", k), waits, (k == 0) ? 2 : 3);
            if (who >= 0) model[who] = ref_apply(model[who], 1, 1'b0);
            if (k == 3) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
        @(negedge clk);
        check_idle_scores("arb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
